leg_multicycle_sequencer: RTL
=============================

# leg_multicycle_sequencer

Multicycle control sequencer for the LEGv8 datapath. It steps each instruction through fetch, decode, execute, memory and writeback states instead of decoding it in one cycle. It drives the shared ALU, register file, PC and unified memory port, and waits on a memory ready handshake. It traps on illegal opcodes or on a memory access that exceeds a timeout.

## Interface

Parameters:
- MEM_TIMEOUT, 15: maximum cycles an access may wait for mem_ready before a fault; legal range 1..255.

Ports:
- clk, input, 1: single clock; all state updates on the rising edge.
- reset_n, input, 1: asynchronous, active-low reset.
- inst, input, 32: current instruction from the instruction register, valid from DECODE onward.
- alu_zero, input, 1: ALU zero flag.
- mem_ready, input, 1: memory has completed the current access.
- pc_write, output, 1: load the PC.
- ir_write, output, 1: load the instruction register.
- i_or_d, output, 1: memory address source; 0 = PC, 1 = ALU result.
- mem_read, output, 1: read request, held until mem_ready.
- mem_write, output, 1: write request, held until mem_ready.
- reg_write, output, 1: register file write enable.
- mem_to_reg, output, 1: writeback source; 0 = ALU, 1 = memory data register.
- reg2loc, output, 1: second read register select; 1 = inst[4:0], 0 = inst[20:16].
- alu_src_a, output, 1: ALU operand A; 0 = PC, 1 = register A.
- alu_src_b, output, 2: ALU operand B; 00 = register B, 01 = constant 4, 10 = sign-extended immediate, 11 = immediate shifted left by 2.
- alu_op, output, 2: 00 = add, 01 = pass B / compare zero, 10 = function-field decode, 11 = wide-immediate move.
- pc_src, output, 2: next PC; 00 = ALU result, 01 = branch target register.
- fault, output, 1: sticky trap flag.
- fault_code, output, 2: 01 = illegal opcode, 10 = memory timeout.
- state, output, 4: current state encoding, for debug.

## Operation

- States and encodings:
  - FETCH=0, DECODE=1, EXEC_R=2, EXEC_I=3, ADDR=4, MEM_RD=5, MEM_WR=6, WB_ALU=7, WB_MEM=8, BRANCH=9, TRAP=15.
- FETCH:
  - i_or_d=0, mem_read=1, ir_write=mem_ready, alu_src_a=0, alu_src_b=01, alu_op=00.
  - On mem_ready: pc_write=1, pc_src=00 (PC+4), then DECODE.
- DECODE:
  - alu_src_a=0, alu_src_b=11, alu_op=00 (branch target precompute).
  - Dispatch on inst[28:26]:
    - 010 (R) → EXEC_R.
    - 100 (I or IM) → EXEC_I.
    - 110 (D) → ADDR.
    - 101 (B/CBZ) → BRANCH.
    - Any other value → TRAP with fault_code=01.
- EXEC_R: alu_src_a=1, alu_src_b=00, alu_op=10, reg2loc=0 → WB_ALU.
- EXEC_I: alu_src_a=1, alu_src_b=10; alu_op=11 if inst[25:23]=101 (IM), else 10 → WB_ALU.
- ADDR: alu_src_a=1, alu_src_b=10, alu_op=00, reg2loc=1.
  - inst[22]=1 (load) → MEM_RD; inst[22]=0 (store) → MEM_WR.
- MEM_RD: i_or_d=1, mem_read=1; on mem_ready → WB_MEM.
- MEM_WR: i_or_d=1, mem_write=1; on mem_ready → FETCH.
- WB_ALU: reg_write=1, mem_to_reg=0 → FETCH.
- WB_MEM: reg_write=1, mem_to_reg=1 → FETCH.
- BRANCH: reg2loc=1, alu_src_a=1, alu_op=01, pc_src=01.
  - Unconditional when inst[31:26] is 000101 or 100101: pc_write=1.
  - Otherwise (CBZ): pc_write=alu_zero.
  - Next state is FETCH.
- TRAP: all enables 0; fault=1; remain in TRAP until reset.
- Wait counter:
  - 8 bits, cleared on every state entry, increments each cycle in FETCH/MEM_RD/MEM_WR while mem_ready=0.
  - Reaching MEM_TIMEOUT → TRAP with fault_code=10; the request is dropped that cycle.
- Outputs not listed for a state are 0. No X values are ever driven.

## Timing

- Reset (asynchronous):
  - state=FETCH, fault=0, fault_code=00, wait counter=0, counters cleared.
  - The combinational outputs then take their FETCH values, so mem_read=1 is driven immediately.
- Cycles per instruction with zero-wait memory (mem_ready high on the first cycle):
  - R, I and IM: 4.
  - Load: 5.
  - Store: 4.
  - Branch: 3.
- Each memory wait cycle adds one cycle. Request signals stay stable throughout the wait.
- mem_ready is sampled only in FETCH, MEM_RD and MEM_WR; it is ignored in all other states.
- If mem_ready arrives on the same cycle the counter reaches MEM_TIMEOUT, mem_ready wins and the access completes.
- reset_n asserted mid-access aborts the access; there is no partial register or PC write.

## Configuration

- PERF_CNT_EN defined:
  - Adds outputs cycle_count[31:0] and retired_count[31:0], both wrapping.
  - cycle_count increments every cycle outside TRAP.
  - retired_count increments on each transition into FETCH from any state other than FETCH.
- Undefined: those ports and counters are absent.

## Test plan

- R-type 0x8B020020 (ADD X0,X1,X2), mem_ready always 1 → states 0,1,2,7,0; reg_write=1 exactly in cycle 4; pc_write=1 in cycle 1.
- Load 0xF8400020 with 2 wait cycles in MEM_RD → 7 total cycles; mem_read and i_or_d=1 held for 3 cycles; mem_to_reg=1 in WB_MEM.
- CBZ 0xB4000040 run twice, once with alu_zero=1 and once with alu_zero=0 → pc_write=1/pc_src=01 in BRANCH for the first, pc_write=0 for the second; both return to FETCH.
- Instruction 0x00000000 → TRAP after DECODE, fault=1, fault_code=01; no enables asserted for 20 further cycles.
- MEM_TIMEOUT=3, mem_ready held 0 in FETCH → TRAP on the 4th cycle, fault_code=10; reset_n pulse low → FETCH with fault=0.
- With PERF_CNT_EN: three R-type instructions at zero wait → retired_count=3, cycle_count=12.

Source files
------------

// File: rtl/leg_multicycle_sequencer.sv
// -----------------------------------------------------------------------------
// leg_multicycle_sequencer
//
// Multicycle control sequencer for a LEGv8 datapath. Each instruction is stepped
// through FETCH -> DECODE -> EXEC/ADDR/BRANCH -> (MEM) -> (WB) -> FETCH. The
// sequencer drives the shared ALU, register file, PC and the unified memory port.
// It traps on an illegal opcode group or on a memory access that times out.
//
// Parameters:
//   MEM_TIMEOUT  cycles an access may wait for mem_ready before trapping (1..255)
//
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   inst[31:0]            instruction register contents (valid from DECODE on)
//   alu_zero              ALU zero flag (CBZ condition)
//   mem_ready             memory access complete
//   pc_write, ir_write    PC / instruction register load enables
//   i_or_d                memory address source (0 = PC, 1 = ALU result)
//   mem_read, mem_write   memory requests, held until mem_ready
//   reg_write, mem_to_reg register file write enable / writeback source
//   reg2loc               second read register select (1 = inst[4:0])
//   alu_src_a, alu_src_b  ALU operand selects
//   alu_op                ALU operation class
//   pc_src                next-PC source (00 = ALU, 01 = branch target register)
//   fault, fault_code     sticky trap flag and cause (01 illegal, 10 timeout)
//   state[3:0]            current state encoding (debug)
//
// Optional build macro PERF_CNT_EN adds cycle_count[31:0] and retired_count[31:0].
// -----------------------------------------------------------------------------
module leg_multicycle_sequencer #(
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] inst,
    input  logic        alu_zero,
    input  logic        mem_ready,
    output logic        pc_write,
    output logic        ir_write,
    output logic        i_or_d,
    output logic        mem_read,
    output logic        mem_write,
    output logic        reg_write,
    output logic        mem_to_reg,
    output logic        reg2loc,
    output logic        alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  alu_op,
    output logic [1:0]  pc_src,
    output logic        fault,
    output logic [1:0]  fault_code,
    output logic [3:0]  state
`ifdef PERF_CNT_EN
    ,
    output logic [31:0] cycle_count,
    output logic [31:0] retired_count
`endif
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_EXEC_R = 4'd2,
        S_EXEC_I = 4'd3,
        S_ADDR   = 4'd4,
        S_MEM_RD = 4'd5,
        S_MEM_WR = 4'd6,
        S_WB_ALU = 4'd7,
        S_WB_MEM = 4'd8,
        S_BRANCH = 4'd9,
        S_TRAP   = 4'd15
    } state_e;

    localparam logic [7:0] TIMEOUT = 8'(MEM_TIMEOUT);

    state_e      state_q, state_d;
    logic [7:0]  wait_q, wait_d;
    logic        fault_q, fault_d;
    logic [1:0]  fault_code_q, fault_code_d;
    logic        wait_inc;
    logic        timeout_hit;
    logic        uncond_branch;

    // Only the opcode-group, IM and load/store bits steer control flow.
    logic        unused_inst_bits;
    assign unused_inst_bits = ^inst[21:0];

    // The counter reaches MEM_TIMEOUT on the edge that follows this cycle; a
    // mem_ready arriving in the same cycle takes priority over the trap.
    assign timeout_hit   = (wait_q + 8'd1) == TIMEOUT;
    assign uncond_branch = (inst[31:26] == 6'b000101) || (inst[31:26] == 6'b100101);

    always_comb begin
        pc_write     = 1'b0;
        ir_write     = 1'b0;
        i_or_d       = 1'b0;
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        reg_write    = 1'b0;
        mem_to_reg   = 1'b0;
        reg2loc      = 1'b0;
        alu_src_a    = 1'b0;
        alu_src_b    = 2'b00;
        alu_op       = 2'b00;
        pc_src       = 2'b00;
        wait_inc     = 1'b0;
        state_d      = state_q;
        fault_code_d = fault_code_q;

        case (state_q)
            S_FETCH: begin
                mem_read  = 1'b1;
                ir_write  = mem_ready;
                alu_src_b = 2'b01;               // PC + 4
                if (mem_ready) begin
                    pc_write = 1'b1;
                    state_d  = S_DECODE;
                end else if (timeout_hit) begin
                    state_d      = S_TRAP;
                    fault_code_d = 2'b10;
                end else begin
                    wait_inc = 1'b1;
                end
            end
            S_DECODE: begin
                alu_src_b = 2'b11;               // precompute branch target
                case (inst[28:26])
                    3'b010:  state_d = S_EXEC_R;
                    3'b100:  state_d = S_EXEC_I;
                    3'b110:  state_d = S_ADDR;
                    3'b101:  state_d = S_BRANCH;
                    default: begin
                        state_d      = S_TRAP;
                        fault_code_d = 2'b01;
                    end
                endcase
            end
            S_EXEC_R: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
                state_d   = S_WB_ALU;
            end
            S_EXEC_I: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_op    = (inst[25:23] == 3'b101) ? 2'b11 : 2'b10;
                state_d   = S_WB_ALU;
            end
            S_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                reg2loc   = 1'b1;
                state_d   = inst[22] ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD, S_MEM_WR: begin
                i_or_d    = 1'b1;
                mem_read  = (state_q == S_MEM_RD);
                mem_write = (state_q == S_MEM_WR);
                if (mem_ready) begin
                    state_d = (state_q == S_MEM_RD) ? S_WB_MEM : S_FETCH;
                end else if (timeout_hit) begin
                    state_d      = S_TRAP;
                    fault_code_d = 2'b10;
                end else begin
                    wait_inc = 1'b1;
                end
            end
            S_WB_ALU: begin
                reg_write = 1'b1;
                state_d   = S_FETCH;
            end
            S_WB_MEM: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                state_d    = S_FETCH;
            end
            S_BRANCH: begin
                reg2loc   = 1'b1;
                alu_src_a = 1'b1;
                alu_op    = 2'b01;
                pc_src    = 2'b01;
                pc_write  = uncond_branch ? 1'b1 : alu_zero;
                state_d   = S_FETCH;
            end
            S_TRAP: begin
                state_d = S_TRAP;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase

        fault_d = (state_d == S_TRAP) ? 1'b1 : fault_q;
        // The wait counter restarts from zero whenever a new state is entered.
        wait_d  = (state_d != state_q) ? 8'd0 : (wait_q + {7'd0, wait_inc});
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_FETCH;
            wait_q       <= 8'd0;
            fault_q      <= 1'b0;
            fault_code_q <= 2'b00;
        end else begin
            state_q      <= state_d;
            wait_q       <= wait_d;
            fault_q      <= fault_d;
            fault_code_q <= fault_code_d;
        end
    end

    assign fault      = fault_q;
    assign fault_code = fault_code_q;
    assign state      = state_q;

`ifdef PERF_CNT_EN
    logic [31:0] cycle_count_q, cycle_count_d;
    logic [31:0] retired_count_q, retired_count_d;

    always_comb begin
        cycle_count_d   = (state_q != S_TRAP) ? cycle_count_q + 32'd1 : cycle_count_q;
        retired_count_d = ((state_d == S_FETCH) && (state_q != S_FETCH))
                          ? retired_count_q + 32'd1 : retired_count_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cycle_count_q   <= 32'd0;
            retired_count_q <= 32'd0;
        end else begin
            cycle_count_q   <= cycle_count_d;
            retired_count_q <= retired_count_d;
        end
    end

    assign cycle_count   = cycle_count_q;
    assign retired_count = retired_count_q;
`endif

endmodule
